// File: rtl/retta_point_loader.sv
// retta_point_loader
//   Upstream sequencer for the line-point scan engine. It collects a 16-byte
//   point table (8 x/y pairs, even address = x, odd address = y) from a
//   valid/ready byte stream. It serves that table on the engine's
//   combinational read port and runs the engine through one START window of
//   SCAN_CYCLES cycles. It then captures the engine's point count and offers
//   it on a valid/ready result port.
//
// Ports
//   clk        in   1  clock, all state updates on posedge
//   rst_n      in   1  asynchronous active-low reset
//   in_valid   in   1  table byte valid
//   in_data    in   8  table byte
//   in_ready   out  1  loader accepts a byte this cycle (IDLE/LOAD)
//   mem_addr   in   4  engine read address
//   mem_data   out  8  table[mem_addr], combinational
//   start      out  1  registered START to engine
//   punti      in   8  engine point-count output
//   res_valid  out  1  result available
//   res_data   out  8  captured point count
//   res_ready  in   1  result consumer accepts
//   busy       out  1  high in every state except IDLE
module retta_point_loader #(
    parameter int unsigned SCAN_CYCLES = 48  // must be >= 42
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    input  logic [3:0] mem_addr,
    output logic [7:0] mem_data,
    output logic       start,
    input  logic [7:0] punti,
    output logic       res_valid,
    output logic [7:0] res_data,
    input  logic       res_ready,
    output logic       busy
);

    localparam int unsigned CW = $clog2(SCAN_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_STOP,
        S_CAPTURE,
        S_OUT
    } state_t;

    state_t        state, state_next;
    logic [7:0]    table_q [16];
    logic [3:0]    wr_ptr;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          last_byte;
    logic          scan_done;

    // in_ready is qualified with rst_n so it reads 0 while reset is held,
    // and drops as soon as the reset is applied.
    assign in_ready  = rst_n && ((state == S_IDLE) || (state == S_LOAD));
    assign accept    = in_valid && in_ready;
    assign last_byte = (state == S_LOAD) && (wr_ptr == 4'd15);
    assign scan_done = (cnt == CW'(SCAN_CYCLES - 1));
    assign mem_data  = table_q[mem_addr];
    assign busy      = (state != S_IDLE);

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (accept) state_next = S_LOAD;
            S_LOAD:    if (accept && last_byte) state_next = S_RUN;
            S_RUN:     if (scan_done) state_next = S_STOP;
            S_STOP:    state_next = S_CAPTURE;
            S_CAPTURE: state_next = S_OUT;
            S_OUT:     if (res_ready) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 16; i++) begin
                table_q[i] <= '0;
            end
            wr_ptr    <= '0;
            cnt       <= '0;
            start     <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        table_q[0] <= in_data;
                        wr_ptr     <= 4'd1;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        table_q[wr_ptr] <= in_data;
                        wr_ptr          <= wr_ptr + 4'd1;  // wraps to 0 after byte 15
                        if (last_byte) begin
                            start <= 1'b1;
                            cnt   <= '0;
                        end
                    end
                end
                S_RUN: begin
                    cnt <= cnt + 1'b1;
                    if (scan_done) begin
                        start <= 1'b0;
                    end
                end
                S_CAPTURE: begin
                    // punti is valid only here; the engine clears it next cycle.
                    res_data  <= punti;
                    res_valid <= 1'b1;
                end
                S_OUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_retta_point_loader.sv
module tb_retta_point_loader;

  localparam int unsigned SC = 48;

  typedef logic [7:0] tbl_t [16];

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready;
  logic [3:0] mem_addr;
  logic [7:0] mem_data;
  logic       start;
  logic [7:0] punti;
  logic       res_valid;
  logic [7:0] res_data;
  logic       res_ready = 1'b0;
  logic       busy;

  logic [3:0] tb_addr = '0;
  logic [3:0] eng_addr;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  retta_point_loader #(.SCAN_CYCLES(SC)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .start(start), .punti(punti),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .busy(busy)
  );

  task automatic chk(input string tag, input bit ok);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $error("FAIL %s", tag);
    end
  endtask

  function automatic int unsigned line_count(input tbl_t t);
    int unsigned n = 0;
    for (int i = 0; i < 8; i++) begin
      if (t[2*i+1] == 8'(2 * int'(t[2*i]) + 2)) n++;
    end
    return n;
  endfunction

  int   eng_ec;
  logic eng_run;
  logic eng_clear;
  tbl_t ebuf;

  assign eng_addr = eng_ec[3:0];
  assign mem_addr = start ? eng_addr : tb_addr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_ec    <= 0;
      eng_run   <= 1'b0;
      eng_clear <= 1'b0;
      punti     <= '0;
    end else begin
      eng_clear <= 1'b0;
      if (eng_clear) punti <= '0;
      if (start) begin
        eng_run <= 1'b1;
        if (eng_ec < 16) ebuf[eng_ec[3:0]] <= mem_data;
        eng_ec <= eng_ec + 1;
      end else if (eng_run) begin
        eng_run   <= 1'b0;
        eng_ec    <= 0;
        punti     <= 8'(line_count(ebuf));
        eng_clear <= 1'b1;
      end
    end
  end

  int   cyc = 0;
  int   st_hi = 0;
  int   st_rise = 0;
  int   acc_cnt = 0;
  int   rv_seen = 0;
  logic st_prev = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    st_prev <= start;
    if (start) st_hi <= st_hi + 1;
    if (start && !st_prev) st_rise <= st_rise + 1;
    if (in_valid && in_ready) acc_cnt <= acc_cnt + 1;
    if (res_valid) rv_seen <= rv_seen + 1;
  end

  task automatic clr_mon();
    st_hi = 0; st_rise = 0; acc_cnt = 0; rv_seen = 0;
  endtask

  int e_cyc;

  task automatic do_load(input tbl_t b, input bit gaps);
    int t;
    for (int i = 0; i < 16; i++) begin
      if (gaps && i[0]) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = b[i];
      t = 0;
      while (!in_ready && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready) begin
        chk("load_timeout", in_ready === 1'b1);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      @(negedge clk);
    end
    e_cyc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic rand_table(output tbl_t t);
    for (int i = 0; i < 8; i++) begin
      t[2*i]   = 8'($urandom);
      t[2*i+1] = ($urandom_range(0, 1) == 1) ? 8'(2 * int'(t[2*i]) + 2) : 8'($urandom);
    end
  endtask

  task automatic check_table(input string tag, input tbl_t exp);
    for (int i = 0; i < 16; i++) begin
      tb_addr = 4'(i);
      #1;
      chk(tag, mem_data === exp[i]);
    end
  endtask

  task automatic finish_scan(input string tag, input tbl_t t, input bit handoff);
    int w = 0;
    while (!res_valid && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_res_valid"}, res_valid === 1'b1);
    chk({tag, "_latency"}, (cyc - e_cyc) === int'(SC + 2));
    chk({tag, "_start_cycles"}, st_hi === int'(SC));
    chk({tag, "_start_rises"}, st_rise === 1);
    chk({tag, "_bytes"}, acc_cnt === 16);
    chk({tag, "_res_data"}, res_data === 8'(line_count(t)));
    if (handoff) begin
      res_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      res_ready = 1'b0;
      chk({tag, "_res_drop"}, res_valid === 1'b0);
      chk({tag, "_idle"}, busy === 1'b0);
    end
  endtask

  initial begin
    tbl_t t1, tz, t8, tr, tr2, hold_tbl;
    logic [7:0] held;

    t1 = '{8'h01, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00,
           8'h00, 8'h02, 8'hFF, 8'h05, 8'h00, 8'h02, 8'h00, 8'h02};
    for (int i = 0; i < 16; i++) begin
      tz[i] = 8'h00;
      t8[i] = i[0] ? 8'h02 : 8'h00;
    end

    #2;
    chk("rst_start", start === 1'b0);
    chk("rst_in_ready", in_ready === 1'b0);
    chk("rst_res_valid", res_valid === 1'b0);
    chk("rst_res_data", res_data === 8'h00);
    chk("rst_busy", busy === 1'b0);
    check_table("rst_table", tz);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", in_ready === 1'b1);

    clr_mon();
    do_load(t1, 1'b0);
    finish_scan("t1", t1, 1'b1);
    chk("t1_count", res_data === 8'd4);
    check_table("t1_table", t1);

    clr_mon();
    do_load(tz, 1'b0);
    finish_scan("zero", tz, 1'b1);
    chk("zero_count", res_data === 8'd0);

    clr_mon();
    do_load(t8, 1'b0);
    finish_scan("eight", t8, 1'b1);
    chk("eight_count", res_data === 8'd8);

    rand_table(tr);
    clr_mon();
    do_load(tr, 1'b1);
    finish_scan("gaps", tr, 1'b1);
    check_table("gaps_table", tr);

    rand_table(hold_tbl);
    clr_mon();
    do_load(hold_tbl, 1'b0);
    finish_scan("hold", hold_tbl, 1'b0);
    held = res_data;
    acc_cnt = 0;
    in_valid = 1'b1;
    in_data = 8'hA5;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("hold_valid", res_valid === 1'b1);
      chk("hold_data", res_data === held);
      chk("hold_in_ready", in_ready === 1'b0);
    end
    in_valid = 1'b0;
    chk("hold_no_accept", acc_cnt === 0);
    chk("hold_busy", busy === 1'b1);
    check_table("hold_table", hold_tbl);
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    chk("hold_release", res_valid === 1'b0);

    rand_table(tr);
    clr_mon();
    do_load(tr, 1'b0);
    repeat (10) @(negedge clk);
    chk("mid_start_on", start === 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_start_off", start === 1'b0);
    chk("mid_busy", busy === 1'b0);
    chk("mid_res_valid", res_valid === 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    clr_mon();
    repeat (70) @(negedge clk);
    chk("mid_no_result", rv_seen === 0);
    chk("mid_no_start", st_hi === 0);
    chk("mid_ready", in_ready === 1'b1);

    rand_table(tr);
    clr_mon();
    do_load(tr, 1'b0);
    finish_scan("fresh", tr, 1'b1);

    for (int k = 0; k < 4; k++) begin
      rand_table(tr2);
      clr_mon();
      do_load(tr2, 1'b0);
      finish_scan("b2b", tr2, 1'b1);
      check_table("b2b_table", tr2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=1 expected=0");
    $fatal(1, "timeout");
  end

endmodule
